// File: rtl/projectile_pkg.sv
// Shared types and constants for the ballistic object bank.
// Latency: n/a (types only). Backpressure: n/a.
// Fixed-point positions carry FRAC_BITS fraction bits. Screen limits are stored pre-shifted.
package projectile_pkg;

    localparam int FRAC_BITS = 6;
    localparam int SPD_W     = 16;
    localparam int PX_W      = 11;
    localparam int POS_W     = PX_W + 1 + FRAC_BITS;
    localparam int FRM_W     = 10;
    localparam int OBJ_W     = 64;
    localparam int OBJ_H     = 64;
    localparam int SAFETY    = 2;
    localparam int SCR_W     = 640;
    localparam int SCR_H     = 480;

    typedef logic signed [POS_W-1:0] fix_t;
    typedef logic signed [SPD_W-1:0] spd_t;

    localparam fix_t X_MIN = fix_t'(SAFETY * (1 << FRAC_BITS));
    localparam fix_t X_MAX = fix_t'((SCR_W - 1 - SAFETY - OBJ_W) * (1 << FRAC_BITS));
    localparam fix_t Y_MIN = fix_t'(SAFETY * (1 << FRAC_BITS));
    localparam fix_t Y_MAX = fix_t'((SCR_H - 1 - SAFETY - OBJ_H) * (1 << FRAC_BITS));

    localparam logic [3:0] EDGE_BOTTOM = 4'd1;
    localparam logic [3:0] EDGE_RIGHT  = 4'd2;
    localparam logic [3:0] EDGE_TOP    = 4'd4;
    localparam logic [3:0] EDGE_LEFT   = 4'd8;
    // Corner codes 0xC, 0x9, 0x6, 0x3 as bits of the 16-entry hit register.
    localparam logic [15:0] CORNER_MASK = 16'h1248;

    typedef enum logic [1:0] {RESOLVE, INTEGRATE, CLAMP} phase_e;

    typedef struct packed {
        logic             active;
        logic             on_ground;
        logic [FRM_W-1:0] frames;
        fix_t             x;
        fix_t             y;
        spd_t             vx;
        spd_t             vy;
    } obj_t;

    // Pull a signed speed towards zero by loss, never crossing zero.
    function automatic spd_t shrink(input spd_t v, input int loss);
        spd_t l;
        l = spd_t'(loss);
        if (v > l) return v - l;
        if (v < -l) return v + l;
        return '0;
    endfunction

endpackage

// File: rtl/projectile_step.sv
// One-object physics step: resolve hits, integrate, or clamp/land, chosen by phase.
// Latency: combinational. Backpressure: none, the caller writes the result back.
module projectile_step
    import projectile_pkg::*;
#(
    parameter int GRAVITY     = 10,
    parameter int MAX_Y_SPEED = 500,
    parameter int HIT_X_LOSS  = 30,
    parameter int HIT_Y_LOSS  = 90,
    parameter int MAX_FRAMES  = 1023
) (
    input  phase_e      phase,
    input  obj_t        cur,
    input  logic [15:0] hits,
    output obj_t        nxt,
    output logic        land
);

    spd_t vx, vy, vx_l, vy_abs;
    fix_t px, py;
    logic any_edge, any_corner;

    always_comb begin
        vx         = cur.vx;
        vy         = cur.vy;
        px         = cur.x;
        py         = cur.y;
        vx_l       = (|hits) ? shrink(vx, HIT_X_LOSS) : vx;
        vy_abs     = (vy < 0) ? -vy : vy;
        any_edge   = hits[EDGE_BOTTOM] | hits[EDGE_TOP] | hits[EDGE_LEFT] | hits[EDGE_RIGHT];
        any_corner = |(hits & CORNER_MASK);
        nxt        = cur;
        land       = 1'b0;
        case (phase)
            RESOLVE: begin
                nxt.vx = vx_l;
                if (hits[EDGE_BOTTOM] && vy > 0) begin
                    nxt.vy        = -shrink(vy, HIT_Y_LOSS);
                    nxt.on_ground = 1'b1;
                end
                if (hits[EDGE_TOP] && vy < 0)     nxt.vy = -vy;
                if (hits[EDGE_LEFT] && vx_l < 0)  nxt.vx = -vx_l;
                if (hits[EDGE_RIGHT] && vx_l > 0) nxt.vx = -vx_l;
                if (!any_edge && any_corner) begin
                    nxt.vx = -vx_l;
                    nxt.vy = -vy;
                end
            end
            INTEGRATE: begin
                // Position moves with the resolved speed; gravity affects the next frame only.
                nxt.x = px + fix_t'(vx);
                nxt.y = py + fix_t'(vy);
                if (vy < spd_t'(MAX_Y_SPEED)) nxt.vy = vy + spd_t'(GRAVITY);
                nxt.frames = cur.frames + FRM_W'(1);
            end
            CLAMP: begin
                if (px < X_MIN)      nxt.x = X_MIN;
                else if (px > X_MAX) nxt.x = X_MAX;
                if (py < Y_MIN)      nxt.y = Y_MIN;
                else if (py > Y_MAX) nxt.y = Y_MAX;
                land = (cur.on_ground && vx == '0 && vy_abs <= spd_t'(HIT_Y_LOSS + GRAVITY)) ||
                       (MAX_FRAMES != 0 && cur.frames == FRM_W'(MAX_FRAMES));
                if (land) begin
                    nxt.active    = 1'b0;
                    nxt.on_ground = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/projectile_bank.sv
// N-object ballistic engine; one shared step datapath swept per frame, 3 cycles per object.
// Latency: launch visible next cycle; frame update done 3*N_OBJ cycles after startOfFrame.
// Backpressure: none; startOfFrame while busy is dropped and flagged in sofOverrun.
module projectile_bank
    import projectile_pkg::*;
#(
    parameter int N_OBJ       = 4,
    parameter int GRAVITY     = 10,
    parameter int MAX_Y_SPEED = 500,
    parameter int HIT_X_LOSS  = 30,
    parameter int HIT_Y_LOSS  = 90,
    parameter int MAX_FRAMES  = 1023
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [N_OBJ-1:0]        launch,
    input  logic signed [PX_W-1:0]  launchX,
    input  logic signed [PX_W-1:0]  launchY,
    input  logic signed [SPD_W-1:0] launchXSpd,
    input  logic signed [SPD_W-1:0] launchYSpd,
    input  logic [N_OBJ-1:0]        collision,
    input  logic [4*N_OBJ-1:0]      HitEdgeCode,
    output logic [N_OBJ*PX_W-1:0]   topLeftX,
    output logic [N_OBJ*PX_W-1:0]   topLeftY,
    output logic [N_OBJ-1:0]        displayObj,
    output logic [N_OBJ-1:0]        landed,
    output logic                    updateBusy,
    output logic                    sofOverrun
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic             busy_q, busy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    phase_e           phase_q, phase_d;

    obj_t        obj_r [N_OBJ];
    logic [15:0] hit_r [N_OBJ];
    obj_t        step_nxt, launch_obj;
    logic        step_land;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            phase_q <= RESOLVE;
        end else begin
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        busy_d  = busy_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (!busy_q) begin
            if (startOfFrame) begin
                busy_d  = 1'b1;
                idx_d   = '0;
                phase_d = RESOLVE;
            end
        end else begin
            case (phase_q)
                RESOLVE:   phase_d = INTEGRATE;
                INTEGRATE: phase_d = CLAMP;
                default: begin
                    phase_d = RESOLVE;
                    if (idx_q == IDX_W'(N_OBJ - 1)) busy_d = 1'b0;
                    else                           idx_d  = idx_q + IDX_W'(1);
                end
            endcase
        end
    end

    always_comb begin
        updateBusy = busy_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                      sofOverrun <= 1'b0;
        else if (startOfFrame && busy_q)  sofOverrun <= 1'b1;
    end

    always_comb begin
        launch_obj        = '0;
        launch_obj.active = 1'b1;
        launch_obj.x      = fix_t'(launchX) <<< FRAC_BITS;
        launch_obj.y      = fix_t'(launchY) <<< FRAC_BITS;
        launch_obj.vx     = launchXSpd;
        launch_obj.vy     = launchYSpd;
    end

    projectile_step #(
        .GRAVITY    (GRAVITY),
        .MAX_Y_SPEED(MAX_Y_SPEED),
        .HIT_X_LOSS (HIT_X_LOSS),
        .HIT_Y_LOSS (HIT_Y_LOSS),
        .MAX_FRAMES (MAX_FRAMES)
    ) u_step (
        .phase(phase_q),
        .cur  (obj_r[idx_q]),
        .hits (hit_r[idx_q]),
        .nxt  (step_nxt),
        .land (step_land)
    );

    for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
        obj_t        obj_q;
        logic [15:0] hit_q;
        logic        land_q, in_slot, load;
        logic [3:0]  code;
        fix_t        x_s, y_s;

        assign in_slot = busy_q && (idx_q == IDX_W'(i));
        assign load    = launch[i] && !obj_q.active && !in_slot;
        assign code    = HitEdgeCode[4*i +: 4];

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                obj_q  <= '0;
                hit_q  <= '0;
                land_q <= 1'b0;
            end else begin
                land_q <= in_slot && obj_q.active && step_land;
                if (in_slot && obj_q.active) obj_q <= step_nxt;
                else if (load)               obj_q <= launch_obj;
                // A hit arriving in the object's own resolve cycle survives the clear.
                if (load)
                    hit_q <= '0;
                else if (obj_q.active)
                    hit_q <= ((in_slot && phase_q == RESOLVE) ? 16'h0 : hit_q) |
                             (collision[i] ? (16'h1 << code) : 16'h0);
            end
        end

        assign obj_r[i]      = obj_q;
        assign hit_r[i]      = hit_q;
        assign x_s           = obj_q.x;
        assign y_s           = obj_q.y;
        assign topLeftX[i*PX_W +: PX_W] = PX_W'(x_s >>> FRAC_BITS);
        assign topLeftY[i*PX_W +: PX_W] = PX_W'(y_s >>> FRAC_BITS);
        assign displayObj[i] = obj_q.active;
        assign landed[i]     = land_q;
    end

endmodule

// File: tb/tb_projectile_bank.sv
// Directed bench for projectile_bank: default instance plus a MAX_FRAMES=3 instance.
module tb_projectile_bank;
    localparam int N = 4;

    logic clk = 1'b0;
    logic resetN, startOfFrame;
    logic [N-1:0] launch, launch2, collision, coll2;
    logic signed [10:0] launchX, launchY;
    logic signed [15:0] launchXSpd, launchYSpd;
    logic [4*N-1:0] HitEdgeCode, hec2;
    logic [N*11-1:0] topLeftX, topLeftY, tlx2, tly2;
    logic [N-1:0] displayObj, landed, disp2, landed2;
    logic updateBusy, sofOverrun, busy2, ovr2;

    int nvec = 0;
    int nerr = 0;
    int land_cnt [N];
    int land2_cnt [N];

    always #5 clk = ~clk;

    projectile_bank dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .launch(launch),
        .launchX(launchX), .launchY(launchY), .launchXSpd(launchXSpd), .launchYSpd(launchYSpd),
        .collision(collision), .HitEdgeCode(HitEdgeCode), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .displayObj(displayObj), .landed(landed), .updateBusy(updateBusy), .sofOverrun(sofOverrun)
    );

    projectile_bank #(.MAX_FRAMES(3)) dut_t (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .launch(launch2),
        .launchX(launchX), .launchY(launchY), .launchXSpd(launchXSpd), .launchYSpd(launchYSpd),
        .collision(coll2), .HitEdgeCode(hec2), .topLeftX(tlx2), .topLeftY(tly2),
        .displayObj(disp2), .landed(landed2), .updateBusy(busy2), .sofOverrun(ovr2)
    );

    function automatic int px(input logic [N*11-1:0] v, input int i);
        logic signed [10:0] f;
        f = v[i*11 +: 11];
        return int'(f);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        for (int k = 0; k < N; k++) begin
            land_cnt[k]  = 0;
            land2_cnt[k] = 0;
        end
        repeat (3*N + 2) begin
            tick();
            for (int k = 0; k < N; k++) begin
                land_cnt[k]  += int'(landed[k]);
                land2_cnt[k] += int'(landed2[k]);
            end
        end
    endtask

    task automatic do_launch(input logic [N-1:0] m, input int x, input int y,
                             input int xs, input int ys);
        launchX    = 11'(x);
        launchY    = 11'(y);
        launchXSpd = 16'(xs);
        launchYSpd = 16'(ys);
        launch     = m;
        tick();
        launch     = '0;
    endtask

    task automatic test_reset();
        int cnt;
        nvec++; if (topLeftX !== '0) begin nerr++; $display("FAIL rst_tlx: got %h want 0", topLeftX); end
        nvec++; if (topLeftY !== '0) begin nerr++; $display("FAIL rst_tly: got %h want 0", topLeftY); end
        nvec++; if (displayObj !== '0) begin nerr++; $display("FAIL rst_disp: got %b want 0", displayObj); end
        nvec++; if (landed !== '0) begin nerr++; $display("FAIL rst_landed: got %b want 0", landed); end
        nvec++; if (updateBusy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", updateBusy); end
        nvec++; if (sofOverrun !== 1'b0) begin nerr++; $display("FAIL rst_ovr: got %b want 0", sofOverrun); end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        cnt = 0;
        repeat (40) begin
            if (updateBusy === 1'b1) cnt++;
            tick();
        end
        nvec++; if (cnt !== 12) begin nerr++; $display("FAIL busy_len: got %0d want 12", cnt); end
    endtask

    task automatic test_launch();
        do_launch(4'b0001, 100, 50, 64, 0);
        nvec++; if (displayObj[0] !== 1'b1) begin nerr++; $display("FAIL l0_disp: got %b want 1", displayObj[0]); end
        nvec++; if (px(topLeftX, 0) !== 100) begin nerr++; $display("FAIL l0_x0: got %0d want 100", px(topLeftX, 0)); end
        nvec++; if (px(topLeftY, 0) !== 50) begin nerr++; $display("FAIL l0_y0: got %0d want 50", px(topLeftY, 0)); end
        do_sof();
        nvec++; if (px(topLeftX, 0) !== 101) begin nerr++; $display("FAIL l0_x1: got %0d want 101", px(topLeftX, 0)); end
        nvec++; if (px(topLeftY, 0) !== 50) begin nerr++; $display("FAIL l0_y1: got %0d want 50", px(topLeftY, 0)); end
        repeat (4) do_sof();
        nvec++; if (px(topLeftX, 0) !== 105) begin nerr++; $display("FAIL l0_x5: got %0d want 105", px(topLeftX, 0)); end
        nvec++; if (px(topLeftY, 0) !== 51) begin nerr++; $display("FAIL l0_y5: got %0d want 51", px(topLeftY, 0)); end
    endtask

    task automatic test_bounce();
        do_launch(4'b0010, 200, 100, 100, 200);
        collision   = 4'b0010;
        HitEdgeCode = 16'h0010;
        tick();
        collision   = '0;
        HitEdgeCode = '0;
        do_sof();
        nvec++; if (px(topLeftX, 1) !== 201) begin nerr++; $display("FAIL b1_x1: got %0d want 201", px(topLeftX, 1)); end
        nvec++; if (px(topLeftY, 1) !== 98) begin nerr++; $display("FAIL b1_y1: got %0d want 98", px(topLeftY, 1)); end
        do_sof();
        nvec++; if (px(topLeftX, 1) !== 202) begin nerr++; $display("FAIL b1_x2: got %0d want 202", px(topLeftX, 1)); end
        nvec++; if (px(topLeftY, 1) !== 96) begin nerr++; $display("FAIL b1_y2: got %0d want 96", px(topLeftY, 1)); end
        do_sof();
        nvec++; if (px(topLeftX, 1) !== 203) begin nerr++; $display("FAIL b1_x3: got %0d want 203", px(topLeftX, 1)); end
        nvec++; if (px(topLeftY, 1) !== 95) begin nerr++; $display("FAIL b1_y3: got %0d want 95", px(topLeftY, 1)); end
    endtask

    task automatic test_land();
        do_launch(4'b0100, 300, 200, 20, 60);
        collision   = 4'b0100;
        HitEdgeCode = 16'h0100;
        tick();
        collision   = '0;
        HitEdgeCode = '0;
        do_sof();
        nvec++; if (displayObj[2] !== 1'b0) begin nerr++; $display("FAIL land_disp: got %b want 0", displayObj[2]); end
        nvec++; if (land_cnt[2] !== 1) begin nerr++; $display("FAIL land_pulses: got %0d want 1", land_cnt[2]); end
        nvec++; if (land_cnt[1] !== 0) begin nerr++; $display("FAIL land_other: got %0d want 0", land_cnt[1]); end
        nvec++; if (px(topLeftX, 2) !== 300) begin nerr++; $display("FAIL land_x: got %0d want 300", px(topLeftX, 2)); end
        nvec++; if (px(topLeftY, 2) !== 200) begin nerr++; $display("FAIL land_y: got %0d want 200", px(topLeftY, 2)); end
    endtask

    task automatic test_clamp();
        do_launch(4'b1000, 570, 100, 640, 0);
        do_sof();
        nvec++; if (px(topLeftX, 3) !== 573) begin nerr++; $display("FAIL clamp_x: got %0d want 573", px(topLeftX, 3)); end
        nvec++; if (px(topLeftY, 3) !== 100) begin nerr++; $display("FAIL clamp_y: got %0d want 100", px(topLeftY, 3)); end
        do_launch(4'b1000, 10, 10, 0, 0);
        nvec++; if (px(topLeftX, 3) !== 573) begin nerr++; $display("FAIL relaunch_x: got %0d want 573", px(topLeftX, 3)); end
        nvec++; if (px(topLeftY, 3) !== 100) begin nerr++; $display("FAIL relaunch_y: got %0d want 100", px(topLeftY, 3)); end
        nvec++; if (displayObj[3] !== 1'b1) begin nerr++; $display("FAIL relaunch_disp: got %b want 1", displayObj[3]); end
    endtask

    task automatic test_slot_collision();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (9) tick();
        collision   = 4'b1000;
        HitEdgeCode = 16'h2000;
        tick();
        collision   = '0;
        HitEdgeCode = '0;
        repeat (6) tick();
        nvec++; if (px(topLeftX, 3) !== 573) begin nerr++; $display("FAIL slot_x0: got %0d want 573", px(topLeftX, 3)); end
        do_sof();
        nvec++; if (px(topLeftX, 3) !== 563) begin nerr++; $display("FAIL slot_x1: got %0d want 563", px(topLeftX, 3)); end
    endtask

    task automatic test_overrun();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        nvec++; if (sofOverrun !== 1'b0) begin nerr++; $display("FAIL ovr_pre: got %b want 0", sofOverrun); end
        repeat (4) tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        nvec++; if (sofOverrun !== 1'b1) begin nerr++; $display("FAIL ovr_set: got %b want 1", sofOverrun); end
        repeat (6) tick();
        nvec++; if (updateBusy !== 1'b1) begin nerr++; $display("FAIL ovr_busy_end: got %b want 1", updateBusy); end
        tick();
        nvec++; if (updateBusy !== 1'b0) begin nerr++; $display("FAIL ovr_busy_drop: got %b want 0", updateBusy); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_sweep();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
        resetN = 1'b0;
        #1;
        nvec++; if (displayObj !== '0) begin nerr++; $display("FAIL mid_disp: got %b want 0", displayObj); end
        nvec++; if (updateBusy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %b want 0", updateBusy); end
        nvec++; if (sofOverrun !== 1'b0) begin nerr++; $display("FAIL mid_ovr: got %b want 0", sofOverrun); end
        nvec++; if (topLeftX !== '0) begin nerr++; $display("FAIL mid_tlx: got %h want 0", topLeftX); end
        nvec++; if (landed !== '0) begin nerr++; $display("FAIL mid_landed: got %b want 0", landed); end
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        launchX    = 11'sd100;
        launchY    = 11'sd100;
        launchXSpd = '0;
        launchYSpd = '0;
        launch2    = 4'b0001;
        tick();
        launch2    = '0;
        do_sof();
        do_sof();
        nvec++; if (disp2[0] !== 1'b1) begin nerr++; $display("FAIL tmo_disp2: got %b want 1", disp2[0]); end
        nvec++; if (land2_cnt[0] !== 0) begin nerr++; $display("FAIL tmo_land2: got %0d want 0", land2_cnt[0]); end
        do_sof();
        nvec++; if (disp2[0] !== 1'b0) begin nerr++; $display("FAIL tmo_disp3: got %b want 0", disp2[0]); end
        nvec++; if (land2_cnt[0] !== 1) begin nerr++; $display("FAIL tmo_land3: got %0d want 1", land2_cnt[0]); end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        launch       = '0;
        launch2      = '0;
        collision    = '0;
        coll2        = '0;
        HitEdgeCode  = '0;
        hec2         = '0;
        launchX      = '0;
        launchY      = '0;
        launchXSpd   = '0;
        launchYSpd   = '0;
        repeat (3) tick();
        resetN = 1'b1;
        tick();
        test_reset();
        test_launch();
        test_bounce();
        test_land();
        test_clamp();
        test_slot_collision();
        test_overrun();
        test_reset_mid_sweep();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
